// File: rtl/postfix_evaluator_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | postfix_evaluator_pkg                                               |
// | Shared operator codes, FSM encoding and data width for the          |
// | infix-to-postfix converter and the postfix evaluator.               |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package postfix_evaluator_pkg;

    localparam int C_DATA_W = 32;

    typedef logic [C_DATA_W-1:0] word_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_DIV = 3'b011,
        OP_EXP = 3'b100,
        OP_EQ  = 3'b101
    } op_e;

    localparam logic [2:0] C_ST_IDLE     = 3'd0;
    localparam logic [2:0] C_ST_EXEC     = 3'd1;
    localparam logic [2:0] C_ST_EXP_LOOP = 3'd2;
    localparam logic [2:0] C_ST_ACK      = 3'd3;
    localparam logic [2:0] C_ST_RESULT   = 3'd4;

endpackage
`default_nettype wire

// File: rtl/eval_alu.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | eval_alu                                                            |
// | Combinational ADD/SUB/MUL/DIV on 32-bit two's-complement words.     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module eval_alu
    import postfix_evaluator_pkg::*;
(
    input  op_e   i_op,
    input  word_t i_a,
    input  word_t i_b,
    output word_t o_result,
    output logic  o_div_by_zero
);

    always_comb begin
        o_result      = '0;
        o_div_by_zero = 1'b0;
        case (i_op)
            OP_ADD: o_result = i_a + i_b;
            OP_SUB: o_result = i_a - i_b;
            OP_MUL: o_result = i_a * i_b;
            OP_DIV: begin
                if (i_b == '0) begin
                    o_div_by_zero = 1'b1;
                end else if (i_b == '1) begin
                    // a / -1 is negation; avoids the MIN/-1 overflow trap
                    o_result = '0 - i_a;
                end else begin
                    o_result = $unsigned($signed(i_a) / $signed(i_b));
                end
            end
            default: o_result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/postfix_evaluator.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | postfix_evaluator                                                   |
// | Stack-based evaluator of postfix token streams with sticky error.   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module postfix_evaluator
    import postfix_evaluator_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        input_stb,
    input  logic [31:0] input_data,
    input  logic        is_input_operator,
    output logic        input_ack,
    output logic        output_stb,
    output logic [31:0] output_data,
    output logic        output_error,
    input  logic        output_ack
);

    localparam int SP_W  = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [2:0]      state_q, state_d;
    logic [SP_W-1:0] sp_q, sp_d;
    logic            err_q, err_d;
    logic            ack_q, ack_d;
    logic            ostb_q, ostb_d;
    word_t           odata_q, odata_d;
    logic            oerr_q, oerr_d;
    word_t           base_q, base_d;
    word_t           exp_q, exp_d;
    word_t           acc_q, acc_d;
    logic [4:0]      cnt_q, cnt_d;

    word_t           stack_q [DEPTH];
    logic            w_wr_en;
    logic [IDX_W-1:0] w_wr_idx;
    word_t           w_wr_data;

    op_e             w_op;
    word_t           w_top;
    word_t           w_next;
    word_t           w_alu_res;
    logic            w_div_zero;
    logic            w_full;
    logic            w_short;
    word_t           w_acc_mul;

    assign w_op      = op_e'(input_data[2:0]);
    assign w_top     = stack_q[IDX_W'(sp_q - SP_W'(1))];
    assign w_next    = stack_q[IDX_W'(sp_q - SP_W'(2))];
    assign w_full    = (sp_q == SP_W'(DEPTH));
    assign w_short   = (sp_q < SP_W'(2));
    assign w_acc_mul = exp_q[0] ? acc_q * base_q : acc_q;

    eval_alu u_alu (
        .i_op          (w_op),
        .i_a           (w_next),
        .i_b           (w_top),
        .o_result      (w_alu_res),
        .o_div_by_zero (w_div_zero)
    );

    always_comb begin
        state_d   = state_q;
        sp_d      = sp_q;
        err_d     = err_q;
        ack_d     = 1'b0;
        ostb_d    = ostb_q;
        odata_d   = odata_q;
        oerr_d    = oerr_q;
        base_d    = base_q;
        exp_d     = exp_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        w_wr_en   = 1'b0;
        w_wr_idx  = '0;
        w_wr_data = '0;
        case (state_q)
            C_ST_IDLE: begin
                if (input_stb) begin
                    if (!is_input_operator) begin
                        state_d = C_ST_ACK;
                        ack_d   = 1'b1;
                        if (!err_q) begin
                            if (w_full) begin
                                err_d = 1'b1;
                            end else begin
                                w_wr_en   = 1'b1;
                                w_wr_idx  = IDX_W'(sp_q);
                                w_wr_data = input_data;
                                sp_d      = sp_q + SP_W'(1);
                            end
                        end
                    end else begin
                        case (w_op)
                            OP_ADD, OP_SUB, OP_MUL, OP_DIV: begin
                                state_d = C_ST_ACK;
                                ack_d   = 1'b1;
                                if (!err_q) begin
                                    if (w_short || (w_op == OP_DIV && w_div_zero)) begin
                                        err_d = 1'b1;
                                    end else begin
                                        w_wr_en   = 1'b1;
                                        w_wr_idx  = IDX_W'(sp_q - SP_W'(2));
                                        w_wr_data = w_alu_res;
                                        sp_d      = sp_q - SP_W'(1);
                                    end
                                end
                            end
                            OP_EXP: begin
                                state_d = C_ST_EXEC;
                                if (!err_q) begin
                                    if (w_short || w_top[31]) begin
                                        err_d = 1'b1;
                                    end
                                    base_d = w_next;
                                    exp_d  = w_top;
                                end
                            end
                            OP_EQ: begin
                                state_d = C_ST_RESULT;
                                ostb_d  = 1'b1;
                                if (sp_q == SP_W'(1) && !err_q) begin
                                    odata_d = w_top;
                                    oerr_d  = 1'b0;
                                end else begin
                                    odata_d = '0;
                                    oerr_d  = 1'b1;
                                end
                            end
                            default: begin
                                state_d = C_ST_ACK;
                                ack_d   = 1'b1;
                                err_d   = 1'b1;
                            end
                        endcase
                    end
                end
            end
            C_ST_EXEC: begin
                acc_d   = word_t'(1);
                cnt_d   = '0;
                state_d = C_ST_EXP_LOOP;
            end
            C_ST_EXP_LOOP: begin
                // LSB-first square-and-multiply, always 32 iterations
                acc_d  = w_acc_mul;
                base_d = base_q * base_q;
                exp_d  = exp_q >> 1;
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = C_ST_ACK;
                    ack_d   = 1'b1;
                    if (!err_q) begin
                        w_wr_en   = 1'b1;
                        w_wr_idx  = IDX_W'(sp_q - SP_W'(2));
                        w_wr_data = w_acc_mul;
                        sp_d      = sp_q - SP_W'(1);
                    end
                end
            end
            C_ST_RESULT: begin
                if (output_ack) begin
                    state_d = C_ST_ACK;
                    ack_d   = 1'b1;
                    ostb_d  = 1'b0;
                    odata_d = '0;
                    oerr_d  = 1'b0;
                    sp_d    = '0;
                    err_d   = 1'b0;
                end
            end
            C_ST_ACK: state_d = C_ST_IDLE;
            default:  state_d = C_ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= C_ST_IDLE;
            sp_q    <= '0;
            err_q   <= 1'b0;
            ack_q   <= 1'b0;
            ostb_q  <= 1'b0;
            odata_q <= '0;
            oerr_q  <= 1'b0;
            base_q  <= '0;
            exp_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            err_q   <= err_d;
            ack_q   <= ack_d;
            ostb_q  <= ostb_d;
            odata_q <= odata_d;
            oerr_q  <= oerr_d;
            base_q  <= base_d;
            exp_q   <= exp_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Stack contents need no reset: the pointer alone defines occupancy
    always_ff @(posedge CLK) begin
        if (RST && w_wr_en) begin
            stack_q[w_wr_idx] <= w_wr_data;
        end
    end

    assign input_ack    = ack_q;
    assign output_stb   = ostb_q;
    assign output_data  = odata_q;
    assign output_error = oerr_q;

endmodule
`default_nettype wire

// File: tb/tb_postfix_evaluator.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_postfix_evaluator                                                |
// | Table-driven expressions with a result scoreboard, plus corners.    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_postfix_evaluator;

    localparam int DEPTH = 16;

    localparam logic [32:0] T_ADD = {1'b1, 32'd0};
    localparam logic [32:0] T_SUB = {1'b1, 32'd1};
    localparam logic [32:0] T_MUL = {1'b1, 32'd2};
    localparam logic [32:0] T_DIV = {1'b1, 32'd3};
    localparam logic [32:0] T_EXP = {1'b1, 32'd4};
    localparam logic [32:0] T_EQ  = {1'b1, 32'd5};
    localparam logic [32:0] T_BAD = {1'b1, 32'd6};
    localparam logic [32:0] T_PAD = 33'd0;

    typedef struct {
        int               n;
        logic [7:0][32:0] tok;
        logic [31:0]      exp_data;
        logic             exp_err;
    } vec_t;

    logic        CLK;
    logic        RST;
    logic        input_stb;
    logic [31:0] input_data;
    logic        is_input_operator;
    logic        input_ack;
    logic        output_stb;
    logic [31:0] output_data;
    logic        output_error;
    logic        output_ack;

    int          total = 0;
    int          bad   = 0;
    int          ack_delay = 0;
    logic [32:0] sb_q[$];
    vec_t        vecs[17];

    postfix_evaluator #(.DEPTH(DEPTH)) dut (
        .CLK               (CLK),
        .RST               (RST),
        .input_stb         (input_stb),
        .input_data        (input_data),
        .is_input_operator (is_input_operator),
        .input_ack         (input_ack),
        .output_stb        (output_stb),
        .output_data       (output_data),
        .output_error      (output_error),
        .output_ack        (output_ack)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [32:0] num(input logic [31:0] v);
        return {1'b0, v};
    endfunction

    function automatic vec_t mk(input logic [31:0] ed, input logic ee, input int n,
                                input logic [32:0] t0, input logic [32:0] t1,
                                input logic [32:0] t2, input logic [32:0] t3,
                                input logic [32:0] t4, input logic [32:0] t5);
        vec_t v;
        v.n        = n;
        v.tok      = '0;
        v.tok[0]   = t0;
        v.tok[1]   = t1;
        v.tok[2]   = t2;
        v.tok[3]   = t3;
        v.tok[4]   = t4;
        v.tok[5]   = t5;
        v.exp_data = ed;
        v.exp_err  = ee;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic send(input logic [32:0] t);
        int  lat;
        bit  got;
        lat = 0;
        got = 1'b0;
        input_data        = t[31:0];
        is_input_operator = t[32];
        input_stb         = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge CLK); #1;
            if (input_ack) begin
                got = 1'b1;
                lat = k;
                break;
            end
        end
        input_stb = 1'b0;
        check("ack_seen", {31'd0, got}, 32'd1);
        if (got) begin
            if (t == T_EXP)
                check("exp_latency_le_34", {31'd0, lat <= 34}, 32'd1);
            else if (t != T_EQ)
                check("ack_latency", lat, 32'd1);
            @(posedge CLK); #1;
            check("ack_width", {31'd0, input_ack}, 32'd0);
        end
    endtask

    task automatic run_vec(input vec_t v);
        sb_q.push_back({v.exp_err, v.exp_data});
        for (int i = 0; i < v.n; i++) send(v.tok[i]);
    endtask

    // Result sink: compares against the scoreboard and handshakes after ack_delay cycles
    bit mon_busy = 1'b0;
    always @(negedge CLK) begin
        if (RST && output_stb && !mon_busy) begin
            logic [32:0] e;
            mon_busy = 1'b1;
            e = '0;
            if (sb_q.size() == 0) begin
                check("sb_unexpected_result", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("result_data", output_data, e[31:0]);
                check("result_error", {31'd0, output_error}, {31'd0, e[32]});
                for (int i = 0; i < ack_delay; i++) begin
                    @(negedge CLK);
                    check("hold_stb", {31'd0, output_stb}, 32'd1);
                    check("hold_data", output_data, e[31:0]);
                    check("hold_error", {31'd0, output_error}, {31'd0, e[32]});
                end
            end
            output_ack = 1'b1;
            @(posedge CLK); #1;
            check("eq_input_ack", {31'd0, input_ack}, 32'd1);
            check("eq_stb_clear", {31'd0, output_stb}, 32'd0);
            check("eq_data_clear", output_data, 32'd0);
            check("eq_error_clear", {31'd0, output_error}, 32'd0);
            output_ack = 1'b0;
            mon_busy   = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(32'd14, 1'b0, 6, num(3), num(4), T_ADD, num(2), T_MUL, T_EQ);
        vecs[1]  = mk(32'd512, 1'b0, 6, num(2), num(3), num(2), T_EXP, T_EXP, T_EQ);
        vecs[2]  = mk(32'd1, 1'b0, 4, num(0), num(0), T_EXP, T_EQ, T_PAD, T_PAD);
        vecs[3]  = mk(32'd0, 1'b1, 4, num(2), num(32'hFFFF_FFFF), T_EXP, T_EQ, T_PAD, T_PAD);
        vecs[4]  = mk(32'hFFFF_FFFD, 1'b0, 4, num(-32'sd7), num(2), T_DIV, T_EQ, T_PAD, T_PAD);
        vecs[5]  = mk(32'd0, 1'b1, 4, num(7), num(0), T_DIV, T_EQ, T_PAD, T_PAD);
        vecs[6]  = mk(32'd5, 1'b0, 2, num(5), T_EQ, T_PAD, T_PAD, T_PAD, T_PAD);
        vecs[7]  = mk(32'd0, 1'b1, 3, num(4), T_ADD, T_EQ, T_PAD, T_PAD, T_PAD);
        vecs[8]  = mk(32'd0, 1'b1, 3, num(1), num(2), T_EQ, T_PAD, T_PAD, T_PAD);
        vecs[9]  = mk(32'd7, 1'b0, 4, num(10), num(3), T_SUB, T_EQ, T_PAD, T_PAD);
        vecs[10] = mk(32'd0, 1'b1, 3, num(1), T_BAD, T_EQ, T_PAD, T_PAD, T_PAD);
        vecs[11] = mk(32'd0, 1'b0, 4, num(65536), num(65536), T_MUL, T_EQ, T_PAD, T_PAD);
        vecs[12] = mk(32'd243, 1'b0, 4, num(3), num(5), T_EXP, T_EQ, T_PAD, T_PAD);
        vecs[13] = mk(32'h8000_0000, 1'b0, 4, num(2), num(31), T_EXP, T_EQ, T_PAD, T_PAD);
        vecs[14] = mk(32'h8000_0000, 1'b0, 4, num(32'h8000_0000), num(32'hFFFF_FFFF), T_DIV, T_EQ, T_PAD, T_PAD);
        vecs[15] = mk(32'd0, 1'b1, 1, T_EQ, T_PAD, T_PAD, T_PAD, T_PAD, T_PAD);
        vecs[16] = mk(32'hFFFF_FFFD, 1'b0, 4, num(7), num(-32'sd2), T_DIV, T_EQ, T_PAD, T_PAD);

        RST = 1'b0; input_stb = 1'b0; input_data = '0;
        is_input_operator = 1'b0; output_ack = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_input_ack", {31'd0, input_ack}, 32'd0);
        check("rst_output_stb", {31'd0, output_stb}, 32'd0);
        check("rst_output_data", output_data, 32'd0);
        check("rst_output_error", {31'd0, output_error}, 32'd0);
        RST = 1'b1;
        @(posedge CLK); #1;

        for (int i = 0; i < 17; i++) run_vec(vecs[i]);

        // Overflow: DEPTH+1 operands
        sb_q.push_back({1'b1, 32'd0});
        for (int i = 0; i <= DEPTH; i++) send(num(i));
        send(T_EQ);

        // Binary operators starting from a full stack: 1+2+...+DEPTH
        sb_q.push_back({1'b0, 32'(DEPTH * (DEPTH + 1) / 2)});
        for (int i = 1; i <= DEPTH; i++) send(num(i));
        for (int i = 1; i < DEPTH; i++) send(T_ADD);
        send(T_EQ);

        // Slow sink
        ack_delay = 5;
        run_vec(mk(32'd2, 1'b0, 4, num(1), num(1), T_ADD, T_EQ, T_PAD, T_PAD));
        ack_delay = 0;

        // Reset in the middle of an EXP loop
        send(num(3));
        send(num(20));
        input_data = T_EXP[31:0]; is_input_operator = 1'b1; input_stb = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1;
            check("exp_no_early_ack", {31'd0, input_ack}, 32'd0);
        end
        RST = 1'b0;
        @(posedge CLK); #1;
        input_stb = 1'b0;
        check("mid_rst_input_ack", {31'd0, input_ack}, 32'd0);
        check("mid_rst_output_stb", {31'd0, output_stb}, 32'd0);
        check("mid_rst_output_data", output_data, 32'd0);
        check("mid_rst_output_error", {31'd0, output_error}, 32'd0);
        @(posedge CLK); #1;
        RST = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK); #1;
            check("post_rst_no_ack", {31'd0, input_ack}, 32'd0);
        end
        run_vec(mk(32'd42, 1'b0, 4, num(6), num(7), T_MUL, T_EQ, T_PAD, T_PAD));

        repeat (5) @(posedge CLK);
        #1;
        check("sb_drained", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
